// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - address map shared by the channel register bank and its per-channel snapshot blocks
package regbank_pkg;

  localparam int         CH_STRIDE     = 8;
  localparam logic [6:0] OFS_CNT0      = 7'd0;
  localparam logic [6:0] OFS_CFG       = 7'd4;
  localparam logic [6:0] ADDR_SNAPSTAT = 7'h7C;
  localparam logic [6:0] ADDR_HWCFG    = 7'h7D;
  localparam logic [6:0] ADDR_WDOGDIV  = 7'h7E;
  localparam logic [6:0] ADDR_CTRL     = 7'h7F;

  function automatic logic [6:0] ch_addr(input int c, input logic [6:0] ofs);
    return 7'(c * CH_STRIDE) + ofs;
  endfunction

endpackage

// File: rtl/chan_snap.sv
// rtl/chan_snap.sv - per-channel read-request synchroniser, freeze level and counter snapshot
module chan_snap
  import regbank_pkg::*;
#(
  parameter int         CNT_BYTES   = 2,
  parameter int         SYNC_STAGES = 3,
  parameter logic [6:0] BASE        = 7'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rdt,
  input  logic [6:0]                   addr,
  input  logic [(CNT_BYTES-1)*8-1:0]   cnt_hi,
  output logic                         freeze,
  output logic                         capture,
  output logic [(CNT_BYTES-1)*8-1:0]   snap
);

  localparam int S = SYNC_STAGES;

  logic [S+1:0]                 rs_q, rs_d;
  logic [(CNT_BYTES-1)*8-1:0]   snap_q, snap_d;
  logic                         rq;

  always_comb begin
    rq      = rdt && (addr == (BASE + OFS_CNT0));
    rs_d    = {rs_q[S:0], rq};
    // One capture per rising edge of the synchronised request, however long rdt stays high
    capture = rs_q[S] && !rs_q[S+1];
    snap_d  = capture ? cnt_hi : snap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q   <= '0;
      snap_q <= '0;
    end else begin
      rs_q   <= rs_d;
      snap_q <= snap_d;
    end
  end

  assign freeze = rs_q[S-1] && !reset;
  assign snap   = snap_q;

endmodule

// File: rtl/chan_regbank.sv
// rtl/chan_regbank.sv - motor channel register bank with asynchronous strobes and frozen tach snapshots
module chan_regbank
  import regbank_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int CNT_BYTES   = 2,
  parameter int SYNC_STAGES = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [6:0]                 addr,
  input  logic                       wrt,
  input  logic                       rdt,
  input  logic [NCH*CNT_BYTES*8-1:0] count,
  input  logic [NCH*8-1:0]           cfgrd,
  input  logic [7:0]                 ctrlrd,
  input  logic [7:0]                 hwconfig,
  output logic [7:0]                 rddata,
  output logic [NCH-1:0]             pwmld,
  output logic [NCH-1:0]             cfgld,
  output logic [NCH-1:0]             freeze,
  output logic                       ctrlld,
  output logic                       wdogdivld,
  output logic                       wdreset
);

  localparam int S  = SYNC_STAGES;
  localparam int CW = CNT_BYTES * 8;

  logic [S:0]                 ws_q, ws_d;
  logic [NCH-1:0]             snapstat_q, snapstat_d;
  logic [NCH-1:0]             capture;
  logic [(CNT_BYTES-1)*8-1:0] snap [NCH];
  logic                       we;
  logic                       stat_clr;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    chan_snap #(
      .CNT_BYTES   (CNT_BYTES),
      .SYNC_STAGES (SYNC_STAGES),
      .BASE        (ch_addr(c, 7'd0))
    ) u_snap (
      .clk     (clk),
      .reset   (reset),
      .rdt     (rdt),
      .addr    (addr),
      .cnt_hi  (count[c*CW+8 +: (CNT_BYTES-1)*8]),
      .freeze  (freeze[c]),
      .capture (capture[c]),
      .snap    (snap[c])
    );
  end

  // Falling edge of the synchronised strobe; ws resets to all ones so reset never fakes an edge
  always_comb begin
    ws_d = {ws_q[S-1:0], wrt};
    we   = ws_q[S] && !ws_q[S-1] && !reset;
  end

  always_comb begin
    pwmld     = '0;
    cfgld     = '0;
    ctrlld    = 1'b0;
    wdogdivld = 1'b0;
    stat_clr  = 1'b0;
    if (we) begin
      ctrlld    = (addr == ADDR_CTRL);
      wdogdivld = (addr == ADDR_WDOGDIV);
      stat_clr  = (addr == ADDR_SNAPSTAT);
      for (int c = 0; c < NCH; c++) begin
        pwmld[c] = (addr == ch_addr(c, OFS_CNT0));
        cfgld[c] = (addr == ch_addr(c, OFS_CFG));
      end
    end
  end

  // A capture landing in the clearing cycle wins so the new snapshot is never hidden
  always_comb begin
    snapstat_d = (stat_clr ? '0 : snapstat_q) | capture;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_q       <= '1;
      snapstat_q <= '0;
    end else begin
      ws_q       <= ws_d;
      snapstat_q <= snapstat_d;
    end
  end

  assign wdreset = rdt && (addr == ADDR_CTRL);

  always_comb begin
    rddata = 8'h00;
    for (int c = 0; c < NCH; c++) begin
      if (addr == ch_addr(c, OFS_CNT0)) rddata = count[c*CW +: 8];
      if (addr == ch_addr(c, OFS_CFG))  rddata = cfgrd[c*8 +: 8];
      for (int b = 1; b < CNT_BYTES; b++) begin
        if (addr == ch_addr(c, 7'(b))) rddata = snap[c][(b-1)*8 +: 8];
      end
    end
    case (addr)
      ADDR_SNAPSTAT: rddata = 8'(snapstat_q);
      ADDR_HWCFG:    rddata = hwconfig;
      ADDR_CTRL:     rddata = ctrlrd;
      default:       ;
    endcase
  end

endmodule
